// File: rtl/multicycle_control.sv
// Moore sequencer and ALU decoder for the multi-cycle RV32I datapath.
// Instructions take 3-5 cycles; mem_ready=0 stretches FETCH, MEMREAD and MEMWRITE.
module multicycle_control #(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         op_code,
   input  logic [2:0]         func3,
   input  logic [6:0]         func7,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               adr_src,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               reg_write,
   output logic [1:0]         result_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [2:0]         imm_type,
   output logic [2:0]         alu_control,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 0,
      S_DECODE   = 1,
      S_MEMADR   = 2,
      S_MEMREAD  = 3,
      S_MEMWB    = 4,
      S_MEMWRITE = 5,
      S_EXEC_R   = 6,
      S_EXEC_I   = 7,
      S_ALUWB    = 8,
      S_JAL      = 9,
      S_BEQ      = 10,
      S_TRAP     = 11
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;

   state_t     state_q, state_d;
   logic [1:0] alu_op;
   logic       pc_write_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c;
   logic       unused_func7;

   assign unused_func7 = ^{func7[6], func7[4:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      pc_write_c  = 1'b0;
      adr_src     = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      illegal_op  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_c = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_write_c = mem_ready;
            pc_write_c = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (op_code)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXEC_R;
               OP_ITYPE:          state_d = S_EXEC_I;
               OP_JAL:            state_d = S_JAL;
               OP_BEQ:            state_d = S_BEQ;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (op_code == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_read_c = 1'b1;
            adr_src    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src  = 2'b01;
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_write_c = 1'b1;
            adr_src     = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            state_d     = S_FETCH;
         end
         // PC takes the target from ALUOut while the ALU forms oldPC+4 for the link.
         S_JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_write_c = 1'b1;
            state_d    = S_ALUWB;
         end
         S_BEQ: begin
            alu_src_a  = 2'b10;
            alu_op     = 2'b01;
            pc_write_c = zero;
            state_d    = S_FETCH;
         end
         S_TRAP: begin
            illegal_op = 1'b1;
         end
         default: state_d = S_TRAP;
      endcase
   end

   always_comb begin
      case (op_code)
         OP_STORE: imm_type = 3'b001;
         OP_BEQ:   imm_type = 3'b010;
         OP_JAL:   imm_type = 3'b011;
         default:  imm_type = 3'b000;
      endcase
   end

   always_comb begin
      alu_control = 3'b111;
      case (alu_op)
         2'b00: alu_control = 3'b000;
         2'b01: alu_control = 3'b001;
         2'b10: begin
            case (func3)
               3'b000:  alu_control = (op_code[5] & func7[5]) ? 3'b001 : 3'b000;
               3'b110:  alu_control = 3'b011;
               3'b111:  alu_control = 3'b010;
               default: alu_control = 3'b111;
            endcase
         end
         default: alu_control = 3'b111;
      endcase
   end

   // Strobes are gated by rst_n so they fall with the reset edge, not the next clock.
   assign pc_write  = pc_write_c  & rst_n;
   assign mem_read  = mem_read_c  & rst_n;
   assign mem_write = mem_write_c & rst_n;
   assign ir_write  = ir_write_c  & rst_n;
   assign reg_write = reg_write_c & rst_n;
   assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: stimulus queues hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op_code = '0;
   logic [2:0] func3 = '0;
   logic [6:0] func7 = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal_op;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] imm_type, alu_control;
   logic [3:0] state;

   multicycle_control #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3), .func7(func7),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_type(imm_type), .alu_control(alu_control),
      .illegal_op(illegal_op), .state(state)
   );

   always #5 clk = ~clk;

   // strobe order: pc_write adr_src mem_read mem_write ir_write reg_write
   typedef struct packed {
      logic [3:0] st;
      logic [5:0] stb;
      logic [1:0] rs;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [2:0] imm;
      logic [2:0] aluc;
      logic       ill;
   } exp_t;

   localparam logic [5:0] S_NONE  = 6'b000000;
   localparam logic [5:0] S_FETCH = 6'b101010;
   localparam logic [5:0] S_FWAIT = 6'b001000;
   localparam logic [5:0] S_RW    = 6'b000001;
   localparam logic [5:0] S_MRD   = 6'b011000;
   localparam logic [5:0] S_MWR   = 6'b010100;
   localparam logic [5:0] S_PC    = 6'b100000;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;
   localparam logic [6:0] OP_J  = 7'b1101111;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_no = 0;

   logic       nxt_rst = 1'b0;
   logic [6:0] nxt_op = '0;
   logic [2:0] nxt_f3 = '0;
   logic [6:0] nxt_f7 = '0;
   logic [2:0] e_imm = '0;

   task automatic set_ins(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [2:0] imm);
      nxt_op = op; nxt_f3 = f3; nxt_f7 = f7; e_imm = imm;
   endtask

   // One clock of stimulus plus the expected outputs for that same cycle.
   task automatic cyc(input logic z, input logic mr, input logic [3:0] st,
                      input logic [5:0] stb, input logic [1:0] rs, input logic [1:0] sa,
                      input logic [1:0] sbv, input logic [2:0] aluc, input logic ill);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = nxt_rst; op_code = nxt_op; func3 = nxt_f3; func7 = nxt_f7;
      zero = z; mem_ready = mr;
      e = '{st: st, stb: stb, rs: rs, sa: sa, sb: sbv, imm: e_imm, aluc: aluc, ill: ill};
      sb_q.push_back(e);
   endtask

   task automatic fetch_ok();   cyc(0, 1, 4'd0, S_FETCH, 2'b10, 2'b00, 2'b10, 3'b000, 0); endtask
   task automatic decode();     cyc(0, 1, 4'd1, S_NONE,  2'b00, 2'b01, 2'b01, 3'b000, 0); endtask
   task automatic in_reset();   cyc(0, 1, 4'd0, S_NONE,  2'b10, 2'b00, 2'b10, 3'b000, 0); endtask
   task automatic aluwb();      cyc(0, 1, 4'd8, S_RW,    2'b00, 2'b00, 2'b00, 3'b000, 0); endtask

   always @(negedge clk) begin
      exp_t e, a;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         a = '{st: state, stb: {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write},
               rs: result_src, sa: alu_src_a, sb: alu_src_b, imm: imm_type,
               aluc: alu_control, ill: illegal_op};
         checks++;
         step_no++;
         if (a !== e) begin
            errors++;
            $display("FAIL step%0d outputs: got st=%0d stb=%b rs=%b sa=%b sb=%b imm=%b aluc=%b ill=%b, want st=%0d stb=%b rs=%b sa=%b sb=%b imm=%b aluc=%b ill=%b",
                     step_no, a.st, a.stb, a.rs, a.sa, a.sb, a.imm, a.aluc, a.ill,
                     e.st, e.stb, e.rs, e.sa, e.sb, e.imm, e.aluc, e.ill);
         end
      end
   end

   initial begin
      // reset state
      nxt_rst = 1'b0;
      set_ins(OP_R, 3'b000, 7'b0000000, 3'b000);
      in_reset();
      nxt_rst = 1'b1;

      // add / sub / addi(f7=0100000) / or / and / xor(invalid)
      fetch_ok(); decode();
      cyc(0, 1, 4'd6, S_NONE, 2'b00, 2'b10, 2'b00, 3'b000, 0); aluwb();
      set_ins(OP_R, 3'b000, 7'b0100000, 3'b000);
      fetch_ok(); decode();
      cyc(0, 1, 4'd6, S_NONE, 2'b00, 2'b10, 2'b00, 3'b001, 0); aluwb();
      set_ins(OP_I, 3'b000, 7'b0100000, 3'b000);
      fetch_ok(); decode();
      cyc(0, 1, 4'd7, S_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 0); aluwb();
      set_ins(OP_R, 3'b110, 7'b0000000, 3'b000);
      fetch_ok(); decode();
      cyc(0, 1, 4'd6, S_NONE, 2'b00, 2'b10, 2'b00, 3'b011, 0); aluwb();
      set_ins(OP_I, 3'b111, 7'b0000000, 3'b000);
      fetch_ok(); decode();
      cyc(0, 1, 4'd7, S_NONE, 2'b00, 2'b10, 2'b01, 3'b010, 0); aluwb();
      set_ins(OP_R, 3'b100, 7'b0000000, 3'b000);
      fetch_ok(); decode();
      cyc(0, 1, 4'd6, S_NONE, 2'b00, 2'b10, 2'b00, 3'b111, 0); aluwb();

      // lw with two wait cycles in MEMREAD: 7 cycles
      set_ins(OP_LW, 3'b010, 7'b0000000, 3'b000);
      fetch_ok(); decode();
      cyc(0, 1, 4'd2, S_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 0);
      cyc(0, 0, 4'd3, S_MRD,  2'b00, 2'b00, 2'b00, 3'b000, 0);
      cyc(0, 0, 4'd3, S_MRD,  2'b00, 2'b00, 2'b00, 3'b000, 0);
      cyc(0, 1, 4'd3, S_MRD,  2'b00, 2'b00, 2'b00, 3'b000, 0);
      cyc(0, 1, 4'd4, S_RW,   2'b01, 2'b00, 2'b00, 3'b000, 0);

      // sw with a FETCH wait and a MEMWRITE wait
      set_ins(OP_SW, 3'b010, 7'b0000000, 3'b001);
      cyc(0, 0, 4'd0, S_FWAIT, 2'b10, 2'b00, 2'b10, 3'b000, 0);
      fetch_ok(); decode();
      cyc(0, 1, 4'd2, S_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 0);
      cyc(0, 0, 4'd5, S_MWR,  2'b00, 2'b00, 2'b00, 3'b000, 0);
      cyc(0, 1, 4'd5, S_MWR,  2'b00, 2'b00, 2'b00, 3'b000, 0);

      // beq taken then not taken
      set_ins(OP_B, 3'b000, 7'b0000000, 3'b010);
      fetch_ok(); decode();
      cyc(1, 1, 4'd10, S_PC,   2'b00, 2'b10, 2'b00, 3'b001, 0);
      fetch_ok(); decode();
      cyc(0, 1, 4'd10, S_NONE, 2'b00, 2'b10, 2'b00, 3'b001, 0);

      // jal
      set_ins(OP_J, 3'b000, 7'b0000000, 3'b011);
      fetch_ok(); decode();
      cyc(0, 1, 4'd9, S_PC, 2'b00, 2'b01, 2'b10, 3'b000, 0);
      aluwb();

      // illegal opcode: sticky TRAP with strobes low whatever the inputs do
      set_ins(7'b0000000, 3'b000, 7'b0000000, 3'b000);
      fetch_ok(); decode();
      for (int i = 0; i < 12; i++)
         cyc(i[1], i[0], 4'd11, S_NONE, 2'b00, 2'b00, 2'b00, 3'b000, 1);

      // reset leaves TRAP; then reset aborts a store waiting in MEMWRITE
      nxt_rst = 1'b0;
      set_ins(OP_SW, 3'b010, 7'b0000000, 3'b001);
      in_reset();
      nxt_rst = 1'b1;
      fetch_ok(); decode();
      cyc(0, 1, 4'd2, S_NONE, 2'b00, 2'b10, 2'b01, 3'b000, 0);
      cyc(0, 0, 4'd5, S_MWR,  2'b00, 2'b00, 2'b00, 3'b000, 0);
      cyc(0, 0, 4'd5, S_MWR,  2'b00, 2'b00, 2'b00, 3'b000, 0);
      nxt_rst = 1'b0;
      cyc(0, 0, 4'd0, S_NONE, 2'b10, 2'b00, 2'b10, 3'b000, 0);
      nxt_rst = 1'b1;

      // clean restart afterwards
      set_ins(OP_R, 3'b000, 7'b0000000, 3'b000);
      fetch_ok(); decode();
      cyc(0, 1, 4'd6, S_NONE, 2'b00, 2'b10, 2'b00, 3'b000, 0); aluwb();

      @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
